// File: rtl/memory_responder_if.sv
// Payload types and bundled channels between a directory bank and the memory responder.
package memory_responder_pkg;

  typedef struct packed {
    logic [5:0]   drid;
    logic [39:0]  paddr;
  } I_drtomem_req_type;

  typedef struct packed {
    logic [5:0]   drid;
    logic [511:0] line;
  } I_memtodr_ack_type;

  typedef struct packed {
    logic [39:0]  paddr;
    logic [511:0] line;
  } I_drtomem_wb_type;

endpackage

interface memory_responder_if;
  import memory_responder_pkg::*;

  logic              drtomem_req_valid;
  logic              drtomem_req_retry;
  I_drtomem_req_type drtomem_req;
  logic              memtodr_ack_valid;
  logic              memtodr_ack_retry;
  I_memtodr_ack_type memtodr_ack;
  logic              drtomem_wb_valid;
  logic              drtomem_wb_retry;
  I_drtomem_wb_type  drtomem_wb;

  modport master (
    output drtomem_req_valid, drtomem_req, memtodr_ack_retry, drtomem_wb_valid, drtomem_wb,
    input  drtomem_req_retry, memtodr_ack_valid, memtodr_ack, drtomem_wb_retry
  );

  modport slave (
    input  drtomem_req_valid, drtomem_req, memtodr_ack_retry, drtomem_wb_valid, drtomem_wb,
    output drtomem_req_retry, memtodr_ack_valid, memtodr_ack, drtomem_wb_retry
  );

endinterface

// File: rtl/memory_responder.sv
// Main-memory endpoint: line store plus fixed-latency, in-order read ack queue.
// Define MEMORY_RESPONDER_STATS_EN to add saturating read/writeback/retry counters.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int MEM_LINES_LOG2 = 12,
  parameter int REQ_DEPTH      = 4,
  parameter int LATENCY        = 20
) (
  input  logic clk,
  input  logic reset,
`ifdef MEMORY_RESPONDER_STATS_EN
  output logic [31:0] stat_reads,
  output logic [31:0] stat_wbs,
  output logic [31:0] stat_retry_cycles,
`endif
  memory_responder_if.slave bus
);

  localparam int         PW    = $clog2(REQ_DEPTH);
  localparam int         LINES = 1 << MEM_LINES_LOG2;
  localparam logic [7:0] LAT   = 8'(LATENCY);

  logic [511:0]            mem [LINES];
  logic [LINES-1:0]        line_valid;

  logic [5:0]              q_drid [REQ_DEPTH];
  logic [511:0]            q_line [REQ_DEPTH];
  logic [7:0]              q_age  [REQ_DEPTH];
  logic [PW:0]             wr_ptr;
  logic [PW:0]             rd_ptr;
  logic [PW-1:0]           wr_slot;
  logic [PW-1:0]           rd_slot;

  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    wb_fire;
  logic                    ack_valid;
  logic [MEM_LINES_LOG2-1:0] req_idx;
  logic [MEM_LINES_LOG2-1:0] wb_idx;
  logic [511:0]            snapshot;
  logic                    unused_paddr;

  assign wr_slot = wr_ptr[PW-1:0];
  assign rd_slot = rd_ptr[PW-1:0];
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_slot == rd_slot);
  assign empty   = (wr_ptr == rd_ptr);

  assign req_idx = bus.drtomem_req.paddr[6 +: MEM_LINES_LOG2];
  assign wb_idx  = bus.drtomem_wb.paddr[6 +: MEM_LINES_LOG2];
  assign unused_paddr = ^{bus.drtomem_req.paddr, bus.drtomem_wb.paddr};

  assign bus.drtomem_req_retry = full;
  assign bus.drtomem_wb_retry  = 1'b0;

  assign wb_fire   = bus.drtomem_wb_valid;
  assign push      = bus.drtomem_req_valid && !full;
  assign ack_valid = !empty && (q_age[rd_slot] == LAT);
  assign pop       = ack_valid && !bus.memtodr_ack_retry;

  assign bus.memtodr_ack_valid = ack_valid;

  // A same-cycle writeback to the requested line wins over the stored copy.
  always_comb begin
    snapshot = '0;
    if (wb_fire && (wb_idx == req_idx)) begin
      snapshot = bus.drtomem_wb.line;
    end else if (line_valid[req_idx]) begin
      snapshot = mem[req_idx];
    end
  end

  always_comb begin
    bus.memtodr_ack = '0;
    if (ack_valid) begin
      bus.memtodr_ack.drid = q_drid[rd_slot];
      bus.memtodr_ack.line = q_line[rd_slot];
    end
  end

  always_ff @(posedge clk) begin
    if (wb_fire) begin
      mem[wb_idx] <= bus.drtomem_wb.line;
    end
  end

  // Clearing the valid bits is what makes the whole store read as zero after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      line_valid <= '0;
    end else if (wb_fire) begin
      line_valid[wb_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Stale slots keep aging harmlessly; a push restarts its slot at zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < REQ_DEPTH; i++) begin
      if (push && (wr_slot == PW'(i))) begin
        q_drid[i] <= bus.drtomem_req.drid;
        q_line[i] <= snapshot;
        q_age[i]  <= '0;
      end else if (q_age[i] != LAT) begin
        q_age[i]  <= q_age[i] + 8'd1;
      end
    end
  end

`ifdef MEMORY_RESPONDER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_reads        <= '0;
      stat_wbs          <= '0;
      stat_retry_cycles <= '0;
    end else begin
      if (push && (stat_reads != '1)) begin
        stat_reads <= stat_reads + 32'd1;
      end
      if (wb_fire && (stat_wbs != '1)) begin
        stat_wbs <= stat_wbs + 32'd1;
      end
      if (bus.drtomem_req_valid && full && (stat_retry_cycles != '1)) begin
        stat_retry_cycles <= stat_retry_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder with an in-order ack scoreboard.
module tb_memory_responder;
  import memory_responder_pkg::*;

  localparam int LATENCY   = 20;
  localparam int REQ_DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  memory_responder_if bus();

`ifdef MEMORY_RESPONDER_STATS_EN
  logic [31:0] stat_reads;
  logic [31:0] stat_wbs;
  logic [31:0] stat_retry_cycles;
`endif

  memory_responder #(
    .MEM_LINES_LOG2(12),
    .REQ_DEPTH(REQ_DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef MEMORY_RESPONDER_STATS_EN
    .stat_reads(stat_reads),
    .stat_wbs(stat_wbs),
    .stat_retry_cycles(stat_retry_cycles),
`endif
    .bus(bus)
  );

  I_memtodr_ack_type sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [5:0] drid, input logic [39:0] paddr,
                               input logic wv, input logic [39:0] wpaddr, input logic [511:0] wline);
    bus.drtomem_req_valid  = rv;
    bus.drtomem_req.drid   = drid;
    bus.drtomem_req.paddr  = paddr;
    bus.drtomem_wb_valid   = wv;
    bus.drtomem_wb.paddr   = wpaddr;
    bus.drtomem_wb.line    = wline;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 6'd0, 40'd0, 1'b0, 40'd0, 512'd0);
  endtask

  task automatic waitAck(input int bound, output int cycles);
    cycles = 0;
    while (bus.memtodr_ack_valid !== 1'b1 && cycles < bound) begin
      tick();
      cycles++;
    end
  endtask

  task automatic expectAckNow(input string tag);
    I_memtodr_ack_type e;
    checkOutput({tag, "_valid"}, 512'(bus.memtodr_ack_valid), 512'(1));
    vectors++;
    assert (sb.size() > 0) else begin
      miscompares++;
      $error("[TB] FAIL %s_sb observed=ack expected=no_ack", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({tag, "_drid"}, 512'(bus.memtodr_ack.drid), 512'(e.drid));
      checkOutput({tag, "_line"}, bus.memtodr_ack.line, e.line);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic seen;
    reset = 1'b0;
    idle();
    bus.memtodr_ack_retry = 1'b0;
    repeat (3) tick();

    // Reset state
    checkOutput("rst_ack_valid", 512'(bus.memtodr_ack_valid), 512'(0));
    checkOutput("rst_ack_drid",  512'(bus.memtodr_ack.drid), 512'(0));
    checkOutput("rst_ack_line",  bus.memtodr_ack.line, 512'(0));
    checkOutput("rst_req_retry", 512'(bus.drtomem_req_retry), 512'(0));
    checkOutput("rst_wb_retry",  512'(bus.drtomem_wb_retry), 512'(0));
    reset = 1'b1;
    tick();

    // Read of an unwritten line, exact latency
    applyStimulus(1'b1, 6'd5, 40'h1000, 1'b0, 40'd0, 512'd0);
    sb.push_back('{6'd5, 512'd0});
    tick();
    idle();
    waitAck(LATENCY + 10, n);
    checkOutput("read_latency", 512'(n), 512'(LATENCY));
    expectAckNow("read_zero");
    tick();
    checkOutput("ack_drop", 512'(bus.memtodr_ack_valid), 512'(0));

    // Writeback then read
    applyStimulus(1'b0, 6'd0, 40'd0, 1'b1, 40'h40, {64{8'hA5}});
    checkOutput("wb_retry", 512'(bus.drtomem_wb_retry), 512'(0));
    tick();
    applyStimulus(1'b1, 6'd1, 40'h40, 1'b0, 40'd0, 512'd0);
    sb.push_back('{6'd1, {64{8'hA5}}});
    tick();
    idle();
    waitAck(LATENCY + 10, n);
    expectAckNow("wb_then_read");
    tick();

    // Same-cycle writeback forwarded into the read snapshot
    applyStimulus(1'b0, 6'd0, 40'd0, 1'b1, 40'h80, {64{8'h11}});
    tick();
    applyStimulus(1'b1, 6'd2, 40'h80, 1'b1, 40'h80, {64{8'h3C}});
    sb.push_back('{6'd2, {64{8'h3C}}});
    tick();
    idle();
    waitAck(LATENCY + 10, n);
    expectAckNow("fwd");
    tick();

    // Fill the queue while acks are blocked
    bus.memtodr_ack_retry = 1'b1;
    for (int i = 0; i < REQ_DEPTH; i++) begin
      applyStimulus(1'b1, 6'(i), 40'h2000 + 40'(i * 64), 1'b0, 40'd0, 512'd0);
      sb.push_back('{6'(i), 512'd0});
      tick();
    end
    applyStimulus(1'b1, 6'd4, 40'h40, 1'b0, 40'd0, 512'd0);
    checkOutput("full_retry", 512'(bus.drtomem_req_retry), 512'(1));
    waitAck(LATENCY + 10, n);
    for (int k = 0; k < 3; k++) begin
      checkOutput("hold_valid", 512'(bus.memtodr_ack_valid), 512'(1));
      checkOutput("hold_drid",  512'(bus.memtodr_ack.drid), 512'(0));
      checkOutput("hold_retry", 512'(bus.drtomem_req_retry), 512'(1));
      tick();
    end
    sb.push_back('{6'd4, {64{8'hA5}}});
    bus.memtodr_ack_retry = 1'b0;
    expectAckNow("ack0");
    tick();
    checkOutput("retry_release", 512'(bus.drtomem_req_retry), 512'(0));
    expectAckNow("ack1");
    tick();
    idle();
    expectAckNow("ack2");
    tick();
    expectAckNow("ack3");
    tick();
    waitAck(LATENCY + 10, n);
    expectAckNow("ack4");
    tick();

    // Reset with queued requests
    bus.memtodr_ack_retry = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 6'(7 + i), 40'h40, 1'b0, 40'd0, 512'd0);
      tick();
    end
    idle();
    waitAck(LATENCY + 10, n);
    checkOutput("pre_reset_valid", 512'(bus.memtodr_ack_valid), 512'(1));
    #2 reset = 1'b0;
    #1;
    checkOutput("reset_drop_valid", 512'(bus.memtodr_ack_valid), 512'(0));
    checkOutput("reset_drop_line",  bus.memtodr_ack.line, 512'(0));
    tick();
    tick();
    reset = 1'b1;
    bus.memtodr_ack_retry = 1'b0;
    seen = 1'b0;
    repeat (LATENCY + 5) begin
      tick();
      if (bus.memtodr_ack_valid === 1'b1) seen = 1'b1;
    end
    checkOutput("no_stale", 512'(seen), 512'(0));
    applyStimulus(1'b1, 6'd10, 40'h40, 1'b0, 40'd0, 512'd0);
    sb.push_back('{6'd10, 512'd0});
    tick();
    idle();
    waitAck(LATENCY + 10, n);
    expectAckNow("post_reset_zero");
    tick();

`ifdef MEMORY_RESPONDER_STATS_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    bus.memtodr_ack_retry = 1'b1;
    for (int i = 0; i < REQ_DEPTH; i++) begin
      applyStimulus(1'b1, 6'(20 + i), 40'h3000, 1'b0, 40'd0, 512'd0);
      tick();
    end
    applyStimulus(1'b1, 6'd30, 40'h3000, 1'b0, 40'd0, 512'd0);
    repeat (4) tick();
    applyStimulus(1'b0, 6'd0, 40'd0, 1'b1, 40'h100, {64{8'h77}});
    tick();
    applyStimulus(1'b0, 6'd0, 40'd0, 1'b1, 40'h140, {64{8'h88}});
    tick();
    idle();
    checkOutput("stat_reads", 512'(stat_reads), 512'(REQ_DEPTH));
    checkOutput("stat_wbs", 512'(stat_wbs), 512'(2));
    checkOutput("stat_retry_cycles", 512'(stat_retry_cycles), 512'(4));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
